// File: rtl/instr_encoder.sv
// Instruction word encoder: buffers decoded fields in a small FIFO, packs them as R/I/JI/JII words
// and writes them sequentially to imem. Optional legality checking is enabled by ENC_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_op,
  input  logic [4:0]               req_aluop,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs,
  input  logic [4:0]               req_rt,
  input  logic [4:0]               req_shamt,
  input  logic [31:0]              req_imm,
  input  logic                     enable,
  input  logic                     addr_load,
  input  logic [ADDR_W-1:0]        addr_in,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err,
  input  logic                     err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] imm;
  } req_t;

  req_t              mem [DEPTH];
  req_t              head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              push, pop, wr, legal, keep;
  logic [31:0]       word;
  logic [ADDR_W-1:0] cnt, wr_addr;

  assign req_ready  = (level < LW'(DEPTH));
  assign fifo_level = level;
  assign push       = req_valid & req_ready;
  assign pop        = enable & (level != '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, aluop: req_aluop, rd: req_rd, rs: req_rs,
                               rt: req_rt, shamt: req_shamt, imm: req_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Unknown opcodes still get an R layout so unchecked builds write something deterministic.
  always_comb begin
    word  = {head.op, head.rd, head.rs, head.rt, head.shamt, head.aluop, 2'b00};
    legal = 1'b1;
    case (head.op)
      5'b00000: ;
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: begin
        word  = {head.op, head.rd, head.rs, head.imm[16:0]};
        legal = (&head.imm[31:16]) | ~(|head.imm[31:16]);
      end
      5'b00001, 5'b00011, 5'b10110, 5'b10101: begin
        word  = {head.op, head.imm[26:0]};
        legal = ~(|head.imm[31:27]);
      end
      5'b00100: word = {head.op, head.rd, 22'd0};
      default:  legal = 1'b0;
    endcase
  end

`ifdef ENC_CHECK_EN
  assign keep = legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (pop & ~legal) | (err & ~err_clr);
  end
`else
  logic unused_chk;
  assign keep       = 1'b1;
  assign err        = 1'b0;
  assign unused_chk = ^{legal, err_clr};
`endif

  assign wr      = pop & keep;
  assign wr_addr = addr_load ? addr_in : cnt;

  // Dropped requests leave the counter alone; addr_load still takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr <= wr_addr;
        imem_data <= word;
        cnt       <= wr_addr + 1'b1;
      end else if (addr_load) begin
        cnt <= addr_in;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic against a queue-based word model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
`ifdef ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [4:0]    req_op = '0, req_aluop = '0, req_rd = '0, req_rs = '0, req_rt = '0, req_shamt = '0;
  logic [31:0]   req_imm = '0;
  logic          enable = 1'b1, addr_load = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          imem_we, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [2:0]    fifo_level;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_aluop(req_aluop), .req_rd(req_rd), .req_rs(req_rs),
    .req_rt(req_rt), .req_shamt(req_shamt), .req_imm(req_imm), .enable(enable),
    .addr_load(addr_load), .addr_in(addr_in), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .fifo_level(fifo_level), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op, alu, rd, rs, rt, sh;
    logic [31:0] imm;
  } req_t;

  req_t mq[$];
  int   m_cnt = 0, m_a = 0;
  bit   m_we = 0, m_err = 0, last_acc = 0;
  logic [31:0] m_d = '0;
  int   checks = 0, errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // {legal, word}, built arithmetically from the field positions of each format
  function automatic logic [32:0] menc(req_t r);
    longint w, si;
    bit ok;
    si = longint'($signed(r.imm));
    ok = 1;
    if (r.op inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6}) begin
      w  = longint'(r.op) * 2**27 + longint'(r.rd) * 2**22 + longint'(r.rs) * 2**17 + (si & 'h1FFFF);
      ok = (si >= -65536) && (si <= 65535);
    end else if (r.op inside {5'd1, 5'd3, 5'd22, 5'd21}) begin
      w  = longint'(r.op) * 2**27 + (si & 'h7FFFFFF);
      ok = (si >= 0) && (si < 2**27);
    end else if (r.op == 5'd4) begin
      w = longint'(r.op) * 2**27 + longint'(r.rd) * 2**22;
    end else begin
      w  = longint'(r.op) * 2**27 + longint'(r.rd) * 2**22 + longint'(r.rs) * 2**17
         + longint'(r.rt) * 2**12 + longint'(r.sh) * 2**7 + longint'(r.alu) * 4;
      ok = (r.op == 5'd0);
    end
    return {ok, w[31:0]};
  endfunction

  task automatic tick();
    req_t r;
    bit push, pop, seterr;
    logic [32:0] e;
    r.op = req_op; r.alu = req_aluop; r.rd = req_rd; r.rs = req_rs;
    r.rt = req_rt; r.sh = req_shamt; r.imm = req_imm;
    push   = req_valid && (mq.size() < DEPTH);
    pop    = enable && (mq.size() > 0);
    seterr = 0;
    m_we   = 0;
    if (pop) begin
      e = menc(mq[0]);
      if (e[32] || !CHK) begin
        m_we  = 1;
        m_a   = addr_load ? int'(addr_in) : m_cnt;
        m_d   = e[31:0];
        m_cnt = (m_a + 1) % (1 << AW);
      end else begin
        seterr = 1;
        if (addr_load) m_cnt = int'(addr_in);
      end
    end else if (addr_load) begin
      m_cnt = int'(addr_in);
    end
    if (CHK) m_err = seterr ? 1'b1 : (err_clr ? 1'b0 : m_err);
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(r);
    last_acc = push;
    #1;
    chk("we", imem_we, m_we);
    chk("addr", imem_addr, m_a);
    chk("data", imem_data, m_d);
    chk("level", fifo_level, mq.size());
    chk("ready", req_ready, mq.size() < DEPTH);
    chk("err", err, m_err);
  endtask

  task automatic set_req(int op, int alu, int rd, int rs, int rt, int sh, logic [31:0] imm);
    req_op = 5'(op); req_aluop = 5'(alu); req_rd = 5'(rd); req_rs = 5'(rs);
    req_rt = 5'(rt); req_shamt = 5'(sh); req_imm = imm; req_valid = 1'b1;
  endtask

  initial begin
    int ops[11] = '{0, 5, 7, 8, 2, 6, 1, 3, 22, 21, 4};
    int n;
    #1;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err", err, 0);
    #12 rst_n = 1'b1;

    // add rd=3 rs=1 rt=2
    set_req(0, 0, 3, 1, 2, 0, 0); tick(); req_valid = 0; tick();
    chk("add_data", imem_data, 32'h00C22000);
    chk("add_addr", imem_addr, 0);
    tick();

    // addi / addi -1 / sub back to back
    set_req(5, 0, 1, 0, 0, 0, 5); tick();
    set_req(5, 0, 1, 0, 0, 0, -1); tick();
    chk("addi5", imem_data, 32'h28400005);
    set_req(0, 1, 4, 5, 6, 0, 0); tick();
    chk("addim1", imem_data, 32'h2841FFFF);
    req_valid = 0; tick();
    chk("sub", imem_data, 32'h010A6004);
    chk("sub_addr", imem_addr, 3);
    tick();

    // fill with writes stalled, then drain; fifth request waits for space
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 4000));
      tick();
    end
    chk("full_ready", req_ready, 0);
    chk("full_level", fifo_level, 4);
    enable = 1;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 10);
    chk("fifth_accept_cycle", n, 2);
    req_valid = 0;
    repeat (5) tick();

    // load 0xFFF and wrap
    addr_load = 1; addr_in = 12'hFFF;
    set_req(1, 0, 0, 0, 0, 0, 100); tick();
    addr_load = 0;
    set_req(4, 0, 31, 0, 0, 0, 0); tick();
    chk("j_data", imem_data, 32'h08000064);
    chk("j_addr", imem_addr, 12'hFFF);
    req_valid = 0; tick();
    chk("jr_data", imem_data, 32'h27C00000);
    chk("jr_addr", imem_addr, 0);
    tick();

    // illegal opcode, out-of-range addi, then a legal add
    set_req(31, 1, 2, 3, 4, 5, 0); tick();
    set_req(5, 0, 1, 2, 0, 0, 70000); tick();
    set_req(0, 0, 3, 1, 2, 0, 0); tick();
    req_valid = 0;
    repeat (3) tick();
`ifdef ENC_CHECK_EN
    chk("err_sticky", err, 1);
    chk("add_after_drop", imem_data, 32'h00C22000);
`endif
    err_clr = 1; tick(); err_clr = 0; tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      int k;
      k = $urandom_range(0, 11);
      req_op    = (k == 11) ? 5'($urandom) : 5'(ops[k]);
      req_aluop = 5'($urandom); req_rd = 5'($urandom); req_rs = 5'($urandom);
      req_rt    = 5'($urandom); req_shamt = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       req_imm = $urandom;
        1:       req_imm = 32'(-$urandom_range(0, 70000));
        default: req_imm = $urandom_range(0, 140000);
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 4) != 0);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_in   = AW'($urandom);
      err_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    req_valid = 0; addr_load = 0; err_clr = 0; enable = 1;
    repeat (6) tick();

    // reset with three entries queued
    enable = 0;
    for (int i = 0; i < 3; i++) begin set_req(0, 0, i, i, i, 0, 0); tick(); end
    req_valid = 0;
    chk("pre_rst_level", fifo_level, 3);
    rst_n = 0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_data", imem_data, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_err", err, 0);
    mq.delete();
    m_cnt = 0; m_a = 0; m_d = '0; m_we = 0; m_err = 0;
    @(posedge clk); #1 rst_n = 1;
    enable = 1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
